// File: rtl/counter_pkg.sv
// Shared opcode encoding for the modulo-N up/down counter.
package counter_pkg;
  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_LOAD = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_STOP = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_UP   = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_DOWN = 3'd4;
endpackage

// File: rtl/counter_mod_reduce.sv
// Combinational data mod N built from an unrolled compare/subtract chain.
module counter_mod_reduce #(
  parameter int N     = 9,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);
  // Worst-case number of subtractions needed for the largest WIDTH-bit input.
  localparam int STAGES = ((1 << WIDTH) - 1) / N;
  // N may equal 2**WIDTH; truncation is harmless because that case has no stages.
  localparam logic [WIDTH-1:0] N_MAX = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] N_SUB = WIDTH'(N);

  logic [WIDTH-1:0] stage [STAGES+1];

  assign stage[0] = data;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign stage[i+1] = (stage[i] > N_MAX) ? stage[i] - N_SUB : stage[i];
  end

  assign result = stage[STAGES];
endmodule

// File: rtl/counter.sv
// Modulo-N up/down counter with synchronous load and a registered wrap pulse.
module counter
  import counter_pkg::*;
#(
  parameter int N     = 9,
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_async,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    data,
  output logic                y,
  output logic [WIDTH-1:0]    result
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

  if (N < 2 || N > (1 << WIDTH)) begin : g_bad_n
    $error("counter: N must satisfy 2 <= N <= 2**WIDTH");
  end

  logic [WIDTH-1:0] data_mod;
  logic [WIDTH-1:0] result_nxt;
  logic             y_nxt;

  counter_mod_reduce #(.N(N), .WIDTH(WIDTH)) u_reduce (
    .data   (data),
    .result (data_mod)
  );

  // Wrap is detected by compare so N below 2**WIDTH never overflows naturally.
  always_comb begin
    result_nxt = result;
    y_nxt      = 1'b0;
    case (opcode)
      OP_LOAD: result_nxt = data_mod;
      OP_UP: begin
        if (result == TOP) begin
          result_nxt = '0;
          y_nxt      = 1'b1;
        end else begin
          result_nxt = result + 1'b1;
        end
      end
      OP_DOWN: begin
        if (result == '0) begin
          result_nxt = TOP;
          y_nxt      = 1'b1;
        end else begin
          result_nxt = result - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_async) begin
      result <= '0;
      y      <= 1'b0;
    end else begin
      result <= result_nxt;
      y      <= y_nxt;
    end
  end
endmodule

// File: tb/tb_counter.sv
// Random and directed checks of counter against an arithmetic reference model.
module tb_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] op [3];
  logic [3:0] d0;
  logic [0:0] d1;
  logic [3:0] d2;
  logic       y0, y1, y2;
  logic [3:0] r0;
  logic [0:0] r1;
  logic [3:0] r2;

  counter #(.N(9), .WIDTH(4)) u0 (
    .clk(clk), .reset_async(rst_n), .opcode(op[0]), .data(d0), .y(y0), .result(r0));
  counter #(.N(2), .WIDTH(1)) u1 (
    .clk(clk), .reset_async(rst_n), .opcode(op[1]), .data(d1), .y(y1), .result(r1));
  counter #(.N(16), .WIDTH(4)) u2 (
    .clk(clk), .reset_async(rst_n), .opcode(op[2]), .data(d2), .y(y2), .result(r2));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int mod_n [3] = '{9, 2, 16};
  int mr [3]    = '{0, 0, 0};
  bit my [3]    = '{0, 0, 0};

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on the opcode rules.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int dv;
      int n;
      n  = mod_n[k];
      dv = (k == 0) ? int'(d0) : (k == 1) ? int'(d1) : int'(d2);
      if (!rst_n) begin
        mr[k] = 0;
        my[k] = 1'b0;
      end else begin
        my[k] = 1'b0;
        case (int'(op[k]))
          1: mr[k] = dv % n;
          3: begin
            my[k] = (mr[k] + 1 == n);
            mr[k] = (mr[k] + 1) % n;
          end
          4: begin
            my[k] = (mr[k] == 0);
            mr[k] = (mr[k] + n - 1) % n;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_r0", 32'(r0), 32'(mr[0]));
      cmp("model_y0", 32'(y0), 32'(my[0]));
      cmp("model_r1", 32'(r1), 32'(mr[1]));
      cmp("model_y1", 32'(y1), 32'(my[1]));
      cmp("model_r2", 32'(r2), 32'(mr[2]));
      cmp("model_y2", 32'(y2), 32'(my[2]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive0(input logic [2:0] o, input logic [3:0] d);
    op[0] = o;
    d0    = d;
    tick();
  endtask

  task automatic lit0(input string name, input int r, input bit yy);
    cmp({name, "_result"}, 32'(r0), 32'(r));
    cmp({name, "_y"}, 32'(y0), 32'(yy));
  endtask

  int up_seq [9] = '{3, 4, 5, 6, 7, 8, 0, 1, 2};

  initial begin
    rst_n = 1'b0;
    op[0] = 3'd3; op[1] = 3'd0; op[2] = 3'd0;
    d0 = '0; d1 = '0; d2 = '0;
    @(negedge clk);

    // Reset held with UP requested
    tick();
    chk_en = 1'b1;
    lit0("reset1", 0, 0);
    tick();
    lit0("reset2", 0, 0);

    rst_n = 1'b1;
    drive0(3'd1, 4'd2);
    lit0("load2", 2, 0);
    for (int i = 0; i < 9; i++) begin
      drive0(3'd3, 4'd2);
      lit0("up_seq", up_seq[i], (i == 6));
    end
    drive0(3'd2, 4'd5);
    lit0("stop_a", 2, 0);
    drive0(3'd2, 4'd5);
    lit0("stop_b", 2, 0);

    drive0(3'd1, 4'd0);
    lit0("load0", 0, 0);
    drive0(3'd4, 4'd0);
    lit0("down_wrap", 8, 1);
    drive0(3'd4, 4'd11);
    lit0("down7", 7, 0);
    drive0(3'd4, 4'd0);
    lit0("down6_data_ignored", 6, 0);

    drive0(3'd1, 4'd13);
    lit0("load13", 4, 0);
    drive0(3'd1, 4'd15);
    lit0("load15", 6, 0);
    drive0(3'd1, 4'd9);
    lit0("load9", 0, 0);
    drive0(3'd1, 4'd8);
    lit0("load8", 8, 0);
    for (int o = 5; o < 8; o++) begin
      drive0(3'(o), 4'd3);
      lit0("reserved_hold", 8, 0);
    end
    drive0(3'd0, 4'd1);
    lit0("nop_hold", 8, 0);

    drive0(3'd1, 4'd3);
    drive0(3'd3, 4'd0);
    lit0("up4", 4, 0);
    rst_n = 1'b0;
    drive0(3'd3, 4'd0);
    lit0("mid_reset", 0, 0);
    rst_n = 1'b1;
    drive0(3'd3, 4'd0);
    lit0("resume1", 1, 0);
    drive0(3'd3, 4'd0);
    lit0("resume2", 2, 0);

    // Full-range sweep of the N=2 and N=16 instances, both directions
    op[0] = 3'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    op[1] = 3'd3; op[2] = 3'd3;
    tick();
    cmp("n2_up_first_r", 32'(r1), 32'd1);
    cmp("n2_up_first_y", 32'(y1), 32'd0);
    tick();
    cmp("n2_up_wrap_r", 32'(r1), 32'd0);
    cmp("n2_up_wrap_y", 32'(y1), 32'd1);
    repeat (31) tick();
    cmp("n16_up_after33", 32'(r2), 32'd1);
    op[1] = 3'd4; op[2] = 3'd4;
    repeat (34) tick();
    cmp("n16_down_after34", 32'(r2), 32'd15);

    // Randomized phase across all three instances
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      for (int k = 0; k < 3; k++) begin
        int v;
        v = $urandom_range(0, 9);
        op[k] = (v >= 8) ? 3'(2 + (v - 6)) : 3'(v);
      end
      d0 = 4'($urandom);
      d1 = 1'($urandom);
      d2 = 4'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
